// File: rtl/hazard_if.sv
// Pipeline-side signal bundle for the hazard/forwarding unit.
// The pipeline drives indices/enables; the hazard unit returns stall, flush, forward and divide controls.
interface hazard_if;
  logic [4:0] rsD, rtD, rsE, rtE;
  logic [4:0] writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW;
  logic       memtoregE, memtoregM;
  logic       branchD, divE, flush_req;
  logic       forwardaD, forwardbD;
  logic [1:0] forwardaE, forwardbE;
  logic       stallF, stallD, stallE, stallM, stallW;
  logic       flushD, flushE, flushM, flushW;
  logic       div_start, div_done;

  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, divE, flush_req,
    input  forwardaD, forwardbD, forwardaE, forwardbE,
           stallF, stallD, stallE, stallM, stallW,
           flushD, flushE, flushM, flushW, div_start, div_done
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
           branchD, divE, flush_req,
    output forwardaD, forwardbD, forwardaE, forwardbE,
           stallF, stallD, stallE, stallM, stallW,
           flushD, flushE, flushM, flushW, div_start, div_done
  );
endinterface

// File: rtl/hazard_unit.sv
// Hazard detection, operand forwarding and multi-cycle divide sequencing for the 5-stage MIPS pipeline.
// Stall/flush/forward outputs are combinational from the inputs and the divide FSM state.
module hazard_unit #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic    clk,
  input  logic    rst,
  hazard_if.slave hz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES - 1);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       start_s;
  logic       lwstall_s, branchstall_s, divstall_s;

  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst,
                                     input logic we);
    return (src != 5'd0) && (src == dst) && we;
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (reg_match(src, hz.writeregM, hz.regwriteM)) begin
      return 2'b10;
    end else if (reg_match(src, hz.writeregW, hz.regwriteW)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  always_comb begin
    hz.forwardaE = fwd_sel(hz.rsE);
    hz.forwardbE = fwd_sel(hz.rtE);
    hz.forwardaD = reg_match(hz.rsD, hz.writeregM, hz.regwriteM);
    hz.forwardbD = reg_match(hz.rtD, hz.writeregM, hz.regwriteM);
  end

  always_comb begin
    lwstall_s     = hz.memtoregE && ((hz.rtE == hz.rsD) || (hz.rtE == hz.rtD));
    branchstall_s = hz.branchD &&
                    ((hz.regwriteE && ((hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD))) ||
                     (hz.memtoregM && ((hz.writeregM == hz.rsD) || (hz.writeregM == hz.rtD))));
    divstall_s    = hz.divE && (state_q != DONE);
  end

  // Divide sequencer: a redirect always wins and returns the FSM to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_s = 1'b0;
    if (hz.flush_req) begin
      state_d = IDLE;
      cnt_d   = 6'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hz.divE) begin
            start_s = 1'b1;
            cnt_d   = CNT_LOAD;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
        BUSY: begin
          if (cnt_q == 6'd0) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Gate the start pulse with reset so a divE held through reset cannot launch the divider.
  always_comb begin
    hz.div_start = start_s && rst;
    hz.div_done  = (state_q == DONE);
    hz.stallF    = 1'b0;
    hz.stallD    = 1'b0;
    hz.stallE    = 1'b0;
    hz.stallM    = 1'b0;
    hz.stallW    = 1'b0;
    hz.flushD    = 1'b0;
    hz.flushE    = 1'b0;
    hz.flushM    = 1'b0;
    hz.flushW    = 1'b0;
    if (hz.flush_req) begin
      hz.flushD = 1'b1;
      hz.flushE = 1'b1;
      hz.flushM = 1'b1;
      hz.flushW = 1'b1;
    end else if (divstall_s) begin
      hz.stallF = 1'b1;
      hz.stallD = 1'b1;
      hz.stallE = 1'b1;
      hz.flushM = 1'b1;
    end else if (lwstall_s || branchstall_s) begin
      hz.stallF = 1'b1;
      hz.stallD = 1'b1;
      hz.flushE = 1'b1;
    end else begin
      hz.stallF = 1'b0;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: table of combinational hazard/forward vectors,
// then cycle sequences for the divide FSM, mid-divide flush and asynchronous reset.
module tb_hazard_unit;

  typedef struct packed {
    logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
    logic       rwE, rwM, rwW, mtrE, mtrM, brD, divE, flush;
  } in_t;

  typedef struct packed {
    logic       faD, fbD;
    logic [1:0] faE, fbE;
    logic [4:0] stall;  // {F,D,E,M,W}
    logic [3:0] flush;  // {D,E,M,W}
    logic       start, done;
  } out_t;

  typedef struct {
    in_t   i;
    out_t  o;
    string nm;
  } vec_t;

  logic clk;
  logic rst;
  hazard_if hz ();

  hazard_unit #(.DIV_CYCLES(32)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  out_t exp_q[$];
  vec_t vecs[$];

  function automatic out_t mko(input logic [1:0] faE, input logic [1:0] fbE,
                               input logic faD, input logic fbD,
                               input logic [4:0] st, input logic [3:0] fl,
                               input logic s, input logic d);
    out_t o;
    o.faD = faD; o.fbD = fbD; o.faE = faE; o.fbE = fbE;
    o.stall = st; o.flush = fl; o.start = s; o.done = d;
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.faD   = hz.forwardaD;
    o.fbD   = hz.forwardbD;
    o.faE   = hz.forwardaE;
    o.fbE   = hz.forwardbE;
    o.stall = {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.stallW};
    o.flush = {hz.flushD, hz.flushE, hz.flushM, hz.flushW};
    o.start = hz.div_start;
    o.done  = hz.div_done;
    return o;
  endfunction

  task automatic drive(input in_t i);
    hz.rsD = i.rsD; hz.rtD = i.rtD; hz.rsE = i.rsE; hz.rtE = i.rtE;
    hz.writeregE = i.wE; hz.writeregM = i.wM; hz.writeregW = i.wW;
    hz.regwriteE = i.rwE; hz.regwriteM = i.rwM; hz.regwriteW = i.rwW;
    hz.memtoregE = i.mtrE; hz.memtoregM = i.mtrM;
    hz.branchD = i.brD; hz.divE = i.divE; hz.flush_req = i.flush;
  endtask

  task automatic check(input string nm);
    out_t got;
    out_t want;
    got  = sample();
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got faD=%b fbD=%b faE=%b fbE=%b stall=%b flush=%b start=%b done=%b, expected faD=%b fbD=%b faE=%b fbE=%b stall=%b flush=%b start=%b done=%b",
               nm, got.faD, got.fbD, got.faE, got.fbE, got.stall, got.flush, got.start, got.done,
               want.faD, want.fbD, want.faE, want.fbE, want.stall, want.flush, want.start, want.done);
    end
  endtask

  // One cycle: drive just after the rising edge, compare on the falling edge.
  task automatic step(input in_t i, input out_t e, input string nm);
    drive(i);
    exp_q.push_back(e);
    @(negedge clk);
    check(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic addv(input in_t i, input out_t o, input string nm);
    vec_t v;
    v.i = i; v.o = o; v.nm = nm;
    vecs.push_back(v);
  endtask

  in_t  t;
  out_t z, s_div, s_start, s_done, s_ld, s_fl;

  initial begin
    z       = mko(2'b00, 2'b00, 1'b0, 1'b0, 5'b00000, 4'b0000, 1'b0, 1'b0);
    s_div   = mko(2'b00, 2'b00, 1'b0, 1'b0, 5'b11100, 4'b0010, 1'b0, 1'b0);
    s_start = mko(2'b00, 2'b00, 1'b0, 1'b0, 5'b11100, 4'b0010, 1'b1, 1'b0);
    s_done  = mko(2'b00, 2'b00, 1'b0, 1'b0, 5'b00000, 4'b0000, 1'b0, 1'b1);
    s_ld    = mko(2'b00, 2'b00, 1'b0, 1'b0, 5'b11000, 4'b0100, 1'b0, 1'b0);
    s_fl    = mko(2'b00, 2'b00, 1'b0, 1'b0, 5'b00000, 4'b1111, 1'b0, 1'b0);

    t = '0; addv(t, z, "idle_zero");
    t = '0; t.rsE = 5'd5; t.wM = 5'd5; t.rwM = 1'b1; t.wW = 5'd5; t.rwW = 1'b1;
    addv(t, mko(2'b10, 2'b00, 1'b0, 1'b0, 5'b0, 4'b0, 1'b0, 1'b0), "fwdA_m_prio");
    t.rwM = 1'b0;
    addv(t, mko(2'b01, 2'b00, 1'b0, 1'b0, 5'b0, 4'b0, 1'b0, 1'b0), "fwdA_w");
    t = '0; t.rsE = 5'd0; t.wM = 5'd0; t.rwM = 1'b1; t.wW = 5'd0; t.rwW = 1'b1;
    addv(t, z, "fwdA_r0");
    t = '0; t.rtE = 5'd7; t.wW = 5'd7; t.rwW = 1'b1;
    addv(t, mko(2'b00, 2'b01, 1'b0, 1'b0, 5'b0, 4'b0, 1'b0, 1'b0), "fwdB_w");
    t.wM = 5'd7; t.rwM = 1'b1;
    addv(t, mko(2'b00, 2'b10, 1'b0, 1'b0, 5'b0, 4'b0, 1'b0, 1'b0), "fwdB_m_prio");
    t = '0; t.rsE = 5'd6; t.wM = 5'd9; t.rwM = 1'b1; t.wW = 5'd6; t.rwW = 1'b0;
    addv(t, z, "fwdA_nomatch");
    t = '0; t.mtrE = 1'b1; t.rtE = 5'd8; t.rsD = 5'd8;
    addv(t, s_ld, "loaduse_rs");
    t.rsD = 5'd9; t.rtD = 5'd10;
    addv(t, z, "loaduse_none");
    t = '0; t.mtrE = 1'b1; t.rtE = 5'd8; t.rtD = 5'd8; t.rsD = 5'd2;
    addv(t, s_ld, "loaduse_rt");
    t = '0; t.brD = 1'b1; t.rwE = 1'b1; t.wE = 5'd3; t.rtD = 5'd3; t.rsD = 5'd1;
    addv(t, s_ld, "branch_E");
    t = '0; t.brD = 1'b1; t.rwE = 1'b1; t.wE = 5'd3; t.rsD = 5'd3; t.rtD = 5'd1;
    addv(t, s_ld, "branch_E_rs");
    t.brD = 1'b0;
    addv(t, z, "nobranch");
    t = '0; t.brD = 1'b1; t.mtrM = 1'b1; t.wM = 5'd3; t.rtD = 5'd3; t.rsD = 5'd1;
    addv(t, s_ld, "branch_loadM");
    t = '0; t.brD = 1'b1; t.rwM = 1'b1; t.wM = 5'd3; t.rtD = 5'd3; t.rsD = 5'd1;
    addv(t, mko(2'b00, 2'b00, 1'b0, 1'b1, 5'b0, 4'b0, 1'b0, 1'b0), "branch_fwdD");
    t = '0; t.rsD = 5'd4; t.wM = 5'd4; t.rwM = 1'b1;
    addv(t, mko(2'b00, 2'b00, 1'b1, 1'b0, 5'b0, 4'b0, 1'b0, 1'b0), "fwdD_a");
    t = '0; t.rwM = 1'b1; t.rtE = 5'd1;
    addv(t, z, "fwdD_r0");
    t = '0; t.mtrE = 1'b1; t.rtE = 5'd8; t.rsD = 5'd8; t.flush = 1'b1;
    addv(t, s_fl, "flush_over_lw");

    rst = 1'b0;
    t = '0;
    drive(t);
    exp_q.push_back(z);
    @(negedge clk);
    check("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].i, vecs[k].o, vecs[k].nm);
    end

    // Full divide with divE held: start in cycle 0, stall 0..32, done in 33.
    t = '0; t.divE = 1'b1;
    for (int c = 0; c <= 33; c++) begin
      if (c == 0)       step(t, s_start, "div_c0");
      else if (c <= 32) step(t, s_div, "div_busy");
      else              step(t, s_done, "div_done");
    end
    step(t, s_start, "div_b2b_start");
    for (int c = 1; c <= 9; c++) step(t, s_div, "div2_busy");
    t.flush = 1'b1;
    step(t, s_fl, "div_mid_flush");
    t.flush = 1'b0;
    step(t, s_start, "div_restart");
    for (int c = 1; c <= 4; c++) step(t, s_div, "div3_busy");

    // Asynchronous reset between edges at divide cycle 5.
    t = '0;
    drive(t);
    rst = 1'b0;
    #2;
    exp_q.push_back(z);
    check("rst_async");
    @(posedge clk);
    #1;
    exp_q.push_back(z);
    check("rst_held");
    rst = 1'b1;
    t.divE = 1'b1;
    for (int c = 0; c <= 33; c++) begin
      if (c == 0)       step(t, s_start, "post_rst_c0");
      else if (c <= 32) step(t, s_div, "post_rst_busy");
      else              step(t, s_done, "post_rst_done");
    end
    t = '0;
    step(t, z, "post_rst_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard and forwarding unit for the 5-stage MIPS core.
- Consumes register indices and write-enables from D/E/M/W.
- Produces the stall/flush controls that the pipeline controller and datapath registers consume, plus forwarding selects.
- Owns a multi-cycle divide sequencer: holds a DIV/DIVU in E until the iterative divider finishes, then releases it to write HI/LO.

Parameters:
- DIV_CYCLES, 32, number of BUSY cycles the divider needs after its start pulse (legal range 2..63).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- rsD, rtD  in  5  source register indices of instruction in D.
- rsE, rtE  in  5  source register indices of instruction in E.
- writeregE, writeregM, writeregW  in  5  destination register index in E/M/W.
- regwriteE, regwriteM, regwriteW  in  1  GPR write enable per stage.
- memtoregE, memtoregM  in  1  stage holds a load.
- branchD  in  1  branch in D (compared in D).
- divE  in  1  DIV/DIVU currently in E.
- flush_req  in  1  exception/ERET redirect; kill all younger work.
- forwardaD, forwardbD  out  1  D-stage compare operand select (1 = ALUOutM).
- forwardaE, forwardbE  out  2  E operand select: 00 = reg file, 01 = ResultW, 10 = ALUOutM.
- stallF, stallD, stallE, stallM, stallW  out  1  hold the stage register.
- flushD, flushE, flushM, flushW  out  1  synchronous clear of the stage register.
- div_start  out  1  one-cycle start pulse to the divider.
- div_done  out  1  one-cycle pulse: divide result valid, E may advance.

Behaviour:
- Reset (rst=0, async): FSM to IDLE, counter to 0. With all inputs 0, every output is 0. Reset mid-divide aborts it; no div_done is produced.
- Forwarding (combinational). Register 0 never matches.
  - forwardaE = 10 if rsE!=0 & rsE==writeregM & regwriteM.
  - Else forwardaE = 01 if rsE!=0 & rsE==writeregW & regwriteW.
  - Else forwardaE = 00.
  - M has priority over W. forwardbE is the same rule using rtE.
  - forwardaD = rsD!=0 & rsD==writeregM & regwriteM; forwardbD uses rtD.
- lwstall = memtoregE & (rtE==rsD | rtE==rtD).
- branchstall = branchD & ((regwriteE & writeregE∈{rsD,rtD}) | (memtoregM & writeregM∈{rsD,rtD})).
- Divide FSM, states IDLE, BUSY, DONE:
  - IDLE: on divE=1 & flush_req=0, assert div_start, load cnt=DIV_CYCLES-1, go BUSY.
  - BUSY: cnt decrements each cycle; when cnt==0 go DONE.
  - DONE: assert div_done; go IDLE next cycle unconditionally.
- divstall = divE & (state!=DONE). A divide is stalled for exactly DIV_CYCLES+1 cycles and occupies E for DIV_CYCLES+2 cycles.
- Back-to-back divides: the second enters E the cycle after DONE (state IDLE) and starts normally.
- Output equations, with priority flush_req > divstall > (lwstall | branchstall):
  - flush_req=1:
    - flushD=flushE=flushM=flushW=1, all stalls 0.
    - FSM forced to IDLE next edge; div_start suppressed.
  - divstall:
    - stallF=stallD=stallE=1, flushM=1 (bubble into M).
    - flushE=0, stallM=stallW=0.
  - lwstall | branchstall: stallF=stallD=1, flushE=1, all others 0.
  - Otherwise all stall/flush outputs 0.
- Stall and flush outputs are combinational from inputs and FSM state; no added latency.
- Invariants:
  - stallX and flushX are never both 1 for the same stage.
  - stallE=1 implies stallD=stallF=1.

Test Plan:
- Forward priority: rsE=5, writeregM=5, regwriteM=1, writeregW=5, regwriteW=1 -> forwardaE=10. Clear regwriteM -> 01. rsE=0 with matches -> 00.
- Load-use: memtoregE=1, rtE=8, rsD=8 -> stallF=stallD=1, flushE=1, stallE=0. Set rsD=9, rtD=10 -> all 0.
- Branch hazard:
  - branchD=1, regwriteE=1, writeregE=3, rtD=3 -> stallD=1, flushE=1.
  - Same with memtoregM=1, writeregM=3, regwriteE=0 -> stallD=1.
  - writeregM=3, regwriteM=1, memtoregM=0 -> no stall, forwardbD=1.
- Divide, DIV_CYCLES=32: hold divE=1 from cycle 0 -> div_start=1 only in cycle 0; stallE=1 and flushM=1 for cycles 0..32; div_done=1 in cycle 33 with stallE=0; state IDLE at cycle 34.
- Mid-divide flush: start a divide, assert flush_req in cycle 10 -> all four flushes=1 that cycle, FSM IDLE at cycle 11, no div_done. Drop flush_req with divE=1 -> new div_start.
- Async reset mid-divide: drive rst=0 between edges at cycle 5 -> div_done and div_start immediately 0. After release with divE=1 -> fresh div_start and 33-cycle stall.
